// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, register index type and writeback-source enum
// for the register-file writeback path.
package regfile_pkg;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 2;
    localparam int NUM_REGS = 2 ** ADDR_W;
    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef enum logic {SRC_ALU = 1'b0, SRC_LD = 1'b1} wb_src_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin grant, req[0]=ALU, req[1]=LD.
// Each grant looks only at the other request, so a ready never depends on its own valid.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic [1:0] req_i,
    input  wb_src_t    rr_i,
    output logic [1:0] gnt_o
);
    assign gnt_o[0] = !req_i[1] || rr_i == SRC_ALU;
    assign gnt_o[1] = !req_i[0] || rr_i == SRC_LD;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between ALU and load writeback,
// registers the winning write and tracks per-register busy bits for decode stalls.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int  DATA_W   = regfile_pkg::DATA_W,
    parameter int  ADDR_W   = regfile_pkg::ADDR_W,
    parameter bit  RR_INIT  = 1'b0,
    localparam int NUM_REGS = 2 ** ADDR_W
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                alu_valid,
    input  logic [ADDR_W-1:0]   alu_reg,
    input  logic [DATA_W-1:0]   alu_data,
    output logic                alu_ready,
    input  logic                ld_valid,
    input  logic [ADDR_W-1:0]   ld_reg,
    input  logic [DATA_W-1:0]   ld_data,
    output logic                ld_ready,
    input  logic                mark_valid,
    input  logic [ADDR_W-1:0]   mark_reg,
    output logic [NUM_REGS-1:0] busy,
    output logic                isWrite,
    output logic [ADDR_W-1:0]   writeReg,
    output logic [DATA_W-1:0]   writeData
);
    logic [1:0]          gnt;
    logic                alu_xfer, ld_xfer;
    wb_src_t             rr_q, rr_d;
    logic                is_write_q;
    logic [ADDR_W-1:0]   write_reg_q, write_reg_d;
    logic [DATA_W-1:0]   write_data_q, write_data_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;

    rr_arb2 u_arb (
        .req_i({ld_valid, alu_valid}),
        .rr_i (rr_q),
        .gnt_o(gnt)
    );

    assign alu_ready = gnt[0];
    assign ld_ready  = gnt[1];
    assign alu_xfer  = alu_valid && gnt[0];
    assign ld_xfer   = ld_valid && gnt[1];

    always_comb begin
        rr_d         = alu_xfer ? SRC_LD : ld_xfer ? SRC_ALU : rr_q;
        write_reg_d  = alu_xfer ? alu_reg : ld_xfer ? ld_reg : write_reg_q;
        write_data_d = alu_xfer ? alu_data : ld_xfer ? ld_data : write_data_q;
        busy_d       = '0;
        // A new mark wins over the clear from the write committing this edge.
        for (int i = 0; i < NUM_REGS; i++)
            busy_d[i] = (mark_valid && mark_reg == ADDR_W'(i)) ||
                        (busy_q[i] && !(is_write_q && write_reg_q == ADDR_W'(i)));
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rr_q         <= wb_src_t'(RR_INIT);
            is_write_q   <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            busy_q       <= '0;
        end else begin
            rr_q         <= rr_d;
            is_write_q   <= alu_xfer || ld_xfer;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            busy_q       <= busy_d;
        end
    end

    assign isWrite   = is_write_q;
    assign writeReg  = write_reg_q;
    assign writeData = write_data_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed stimulus pushes expected writes into a queue;
// a negedge monitor pops and compares every committed register-file write.
module tb_regfile_wb_arbiter;
    logic       CLK = 1'b0;
    logic       RST_N;
    logic       alu_valid, ld_valid, mark_valid;
    logic [1:0] alu_reg, ld_reg, mark_reg;
    logic [7:0] alu_data, ld_data;
    logic       alu_ready, ld_ready, isWrite;
    logic [3:0] busy;
    logic [1:0] writeReg;
    logic [7:0] writeData;

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];

    regfile_wb_arbiter dut (
        .CLK(CLK), .RST_N(RST_N),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_reg(ld_reg), .ld_data(ld_data), .ld_ready(ld_ready),
        .mark_valid(mark_valid), .mark_reg(mark_reg), .busy(busy),
        .isWrite(isWrite), .writeReg(writeReg), .writeData(writeData)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (RST_N === 1'b1 && isWrite === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got reg %0d data %0h expected none", writeReg, writeData);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if ({writeReg, writeData} !== e) begin
                    errors++;
                    $display("FAIL write: got reg %0d data %0h expected reg %0d data %0h",
                             writeReg, writeData, e[9:8], e[7:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        RST_N = 1'b0;
        {alu_valid, ld_valid, mark_valid} = '0;
        {alu_reg, ld_reg, mark_reg} = '0;
        {alu_data, ld_data} = '0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        chk("rst_iswrite", 32'(isWrite), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_wreg", 32'(writeReg), 0);
        // Test 1: async reset in the middle of a write
        mark_valid = 1; mark_reg = 2;
        alu_valid = 1; alu_reg = 1; alu_data = 8'h33;
        exp_q.push_back({2'd1, 8'h33});
        #1 chk("t1_alu_ready", 32'(alu_ready), 1);
        @(negedge CLK);
        alu_valid = 0; mark_valid = 0;
        chk("t1_iswrite_pre", 32'(isWrite), 1);
        chk("t1_busy_pre", 32'(busy), 4'b0100);
        #2 RST_N = 0;
        #1;
        chk("t1_iswrite_rst", 32'(isWrite), 0);
        chk("t1_wreg_rst", 32'(writeReg), 0);
        chk("t1_busy_rst", 32'(busy), 0);
        @(negedge CLK);
        RST_N = 1;
        // Test 3: both valid, alternating grants starting at ALU
        alu_valid = 1; alu_reg = 0; alu_data = 8'h11;
        ld_valid = 1; ld_reg = 3; ld_data = 8'h22;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back((k % 2 == 0) ? {2'd0, 8'h11} : {2'd3, 8'h22});
            #1;
            chk("t3_alu_ready", 32'(alu_ready), (k % 2 == 0) ? 1 : 0);
            chk("t3_ld_ready", 32'(ld_ready), (k % 2 == 1) ? 1 : 0);
            @(negedge CLK);
        end
        alu_valid = 0; ld_valid = 0;
        chk("t3_iswrite_last", 32'(isWrite), 1);
        @(negedge CLK);
        chk("t3_iswrite_idle", 32'(isWrite), 0);
        // Test 2: single ALU write, rr now ALU
        alu_valid = 1; alu_reg = 2; alu_data = 8'hA5;
        exp_q.push_back({2'd2, 8'hA5});
        #1 chk("t2_alu_ready", 32'(alu_ready), 1);
        @(negedge CLK);
        alu_valid = 0;
        chk("t2_iswrite", 32'(isWrite), 1);
        @(negedge CLK);
        // Test 4: same destination, rr=LD so LD first then ALU
        alu_valid = 1; alu_reg = 1; alu_data = 8'h66;
        ld_valid = 1; ld_reg = 1; ld_data = 8'h77;
        exp_q.push_back({2'd1, 8'h77});
        exp_q.push_back({2'd1, 8'h66});
        #1;
        chk("t4_ld_ready", 32'(ld_ready), 1);
        chk("t4_alu_ready", 32'(alu_ready), 0);
        @(negedge CLK);
        ld_valid = 0;
        #1 chk("t4_alu_ready2", 32'(alu_ready), 1);
        @(negedge CLK);
        alu_valid = 0;
        @(negedge CLK);
        chk("t4_iswrite_idle", 32'(isWrite), 0);
        chk("t4_hold_reg", 32'(writeReg), 1);
        chk("t4_hold_data", 32'(writeData), 8'h66);
        // Test 5: mark then clear by write
        mark_valid = 1; mark_reg = 3;
        @(negedge CLK);
        mark_valid = 0;
        chk("t5_busy_set", 32'(busy), 4'b1000);
        alu_valid = 1; alu_reg = 3; alu_data = 8'h99;
        exp_q.push_back({2'd3, 8'h99});
        @(negedge CLK);
        alu_valid = 0;
        chk("t5_busy_during", 32'(busy), 4'b1000);
        @(negedge CLK);
        chk("t5_busy_clear", 32'(busy), 0);
        // Test 6: mark and clear of reg 0 on the same edge
        alu_valid = 1; alu_reg = 0; alu_data = 8'h5A;
        exp_q.push_back({2'd0, 8'h5A});
        @(negedge CLK);
        alu_valid = 0;
        mark_valid = 1; mark_reg = 0;
        chk("t6_iswrite", 32'(isWrite), 1);
        @(negedge CLK);
        mark_valid = 0;
        chk("t6_busy_set_wins", 32'(busy), 4'b0001);
        @(negedge CLK);
        chk("t6_busy_hold", 32'(busy), 4'b0001);
        repeat (2) @(negedge CLK);
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
